// File: rtl/mdu_controller.sv
// mdu_controller
// Multiply/divide unit for the Execute stage. Owns the architectural HI/LO
// registers, launches multi-cycle MULT/MULTU/DIV/DIVU operations and holds
// their results in shadow registers until a down-counter expires, at which
// point HI/LO are committed in one edge.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   op         E-stage MDU opcode (0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU,
//              5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 NONE)
//   operand1   forwarded rs value
//   operand2   forwarded rt value
//   start      combinational: a multiply/divide is accepted this cycle
//   busy       an operation is in flight (decoded from the counter register)
//   HI, LO     architectural HI/LO registers
//   read_data  combinational MFHI/MFLO result, 0 for every other op
module mdu_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] read_data
);

  localparam int DATA_W     = 32;
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } op_e;

  logic [DATA_W-1:0]   hi_next;
  logic [DATA_W-1:0]   lo_next;
  logic [CNT_W-1:0]    count;
  logic                div_zero;
  logic [2*DATA_W-1:0] result;
  logic                is_mul;
  logic                is_div;
  logic                div_by_zero;

  // Signed 32x32 -> 64 product; operands are sign-extended so the low 64
  // bits of the product are exact.
  function automatic logic [2*DATA_W-1:0] mul_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] ax;
    logic signed [2*DATA_W-1:0] bx;
    ax = {{DATA_W{a[DATA_W-1]}}, a};
    bx = {{DATA_W{b[DATA_W-1]}}, b};
    return ax * bx;
  endfunction

  function automatic logic [2*DATA_W-1:0] mul_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [2*DATA_W-1:0] ax;
    logic [2*DATA_W-1:0] bx;
    ax = {{DATA_W{1'b0}}, a};
    bx = {{DATA_W{1'b0}}, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}. The one overflowing case (most negative
  // value divided by -1) is pinned to quotient=0x80000000, remainder=0.
  // A zero divisor returns 0; the result is discarded at commit anyway.
  function automatic logic [2*DATA_W-1:0] div_signed(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [DATA_W-1:0] q;
    logic signed [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else if (a == {1'b1, {(DATA_W-1){1'b0}}} && b == {DATA_W{1'b1}}) begin
      q = a;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [2*DATA_W-1:0] div_unsigned(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] r;
    if (b == '0) begin
      q = '0;
      r = '0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  assign is_mul      = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div      = (op == OP_DIV) || (op == OP_DIVU);
  assign div_by_zero = is_div && (operand2 == '0);
  assign busy        = (count != '0);
  assign start       = (is_mul || is_div) && !busy;

  always_comb begin
    read_data = '0;
    case (op)
      OP_MFHI: read_data = HI;
      OP_MFLO: read_data = LO;
      default: read_data = '0;
    endcase
  end

  always_comb begin
    result = '0;
    case (op)
      OP_MULT:  result = mul_signed(operand1, operand2);
      OP_MULTU: result = mul_unsigned(operand1, operand2);
      OP_DIV:   result = div_signed(operand1, operand2);
      OP_DIVU:  result = div_unsigned(operand1, operand2);
      default:  result = '0;
    endcase
  end

  // Busy takes priority over every new op: starts and MTHI/MTLO that arrive
  // while an operation is in flight are dropped. The commit happens on the
  // edge where the counter steps from 1 to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI       <= '0;
      LO       <= '0;
      hi_next  <= '0;
      lo_next  <= '0;
      count    <= '0;
      div_zero <= 1'b0;
    end else if (busy) begin
      count <= count - CNT_W'(1);
      if (count == CNT_W'(1) && !div_zero) begin
        HI <= hi_next;
        LO <= lo_next;
      end
    end else if (start) begin
      hi_next  <= result[2*DATA_W-1:DATA_W];
      lo_next  <= result[DATA_W-1:0];
      count    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      div_zero <= div_by_zero;
    end else if (op == OP_MTHI) begin
      HI <= operand1;
    end else if (op == OP_MTLO) begin
      LO <= operand1;
    end
  end

endmodule
